// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package regfile_pkg;
   localparam int DATA_W = 16;
   localparam int NREG   = 16;
   localparam int ADDR_W = 4;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-back sources / decode (master) and the arbiter (slave).
interface regfile_wb_arbiter_if;
   import regfile_pkg::*;

   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_reg;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic              b_ready;
   logic [ADDR_W-1:0] b_reg;
   logic [DATA_W-1:0] b_data;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_reg;
   logic [ADDR_W-1:0] read_reg1;
   logic [ADDR_W-1:0] read_reg2;
   logic              busy1;
   logic              busy2;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;
   logic              reg_write_en;

   modport master (
      output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
             issue_valid, issue_reg, read_reg1, read_reg2,
      input  a_ready, b_ready, busy1, busy2, write_reg, write_data, reg_write_en
   );

   modport slave (
      input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
             issue_valid, issue_reg, read_reg1, read_reg2,
      output a_ready, b_ready, busy1, busy2, write_reg, write_data, reg_write_en
   );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; req/gnt bit 0 is source A, bit 1 is source B.
//   state  | meaning
//   SRC_A  | A won the most recent grant, B has priority on contention
//   SRC_B  | B won the most recent grant (reset), A has priority on contention
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   src_t last_grant_q, last_grant_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_grant_q <= SRC_B;
      else       last_grant_q <= last_grant_d;
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (gnt_o[0])      last_grant_d = SRC_A;
      else if (gnt_o[1]) last_grant_d = SRC_B;
   end

   // Grants are suppressed while reset is held so no transfer is accepted and then lost.
   always_comb begin
      gnt_o = 2'b00;
      if (!reset) begin
         unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_grant_q == SRC_A) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between sources A and B, registers the write command
// and tracks in-flight destinations in a busy-bit scoreboard for RAW hazard detection.
module regfile_wb_arbiter
   import regfile_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   regfile_wb_arbiter_if.slave bus
);

   logic [1:0]        gnt;
   logic [ADDR_W-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic              wen_q, wen_d;
   logic [NREG-1:0]   busy_q, busy_d;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req_i ({bus.b_valid, bus.a_valid}),
      .gnt_o (gnt)
   );

   assign bus.a_ready = gnt[0];
   assign bus.b_ready = gnt[1];

   always_comb begin
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      wen_d        = |gnt;
      if (gnt[0]) begin
         write_reg_d  = bus.a_reg;
         write_data_d = bus.a_data;
      end else if (gnt[1]) begin
         write_reg_d  = bus.b_reg;
         write_data_d = bus.b_data;
      end
   end

   // Clear before set so an issue to the register being committed keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (wen_q)           busy_d[write_reg_q]   = 1'b0;
      if (bus.issue_valid) busy_d[bus.issue_reg] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_reg_q  <= '0;
         write_data_q <= '0;
         wen_q        <= 1'b0;
         busy_q       <= '0;
      end else begin
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         wen_q        <= wen_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.write_reg    = write_reg_q;
   assign bus.write_data   = write_data_q;
   assign bus.reg_write_en = wen_q;
   assign bus.busy1        = busy_q[bus.read_reg1];
   assign bus.busy2        = busy_q[bus.read_reg2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write latency, scoreboard, reset.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fails;

   regfile_wb_arbiter_if wb_if ();

   regfile_wb_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (wb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_write(input string tag, input logic en, input logic [3:0] r,
                              input logic [15:0] d);
      check({tag, "_wen"},  32'(wb_if.reg_write_en), 32'(en));
      check({tag, "_wreg"}, 32'(wb_if.write_reg),    32'(r));
      check({tag, "_wdat"}, 32'(wb_if.write_data),   32'(d));
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      reset = 1'b1;
      wb_if.a_valid = 1'b0; wb_if.a_reg = '0; wb_if.a_data = '0;
      wb_if.b_valid = 1'b0; wb_if.b_reg = '0; wb_if.b_data = '0;
      wb_if.issue_valid = 1'b0; wb_if.issue_reg = '0;
      wb_if.read_reg1 = '0; wb_if.read_reg2 = '0;

      repeat (2) @(posedge clk);
      #1;
      check_write("rst", 1'b0, 4'd0, 16'h0000);
      check("rst_busy1", 32'(wb_if.busy1), 32'd0);
      check("rst_busy2", 32'(wb_if.busy2), 32'd0);
      reset = 1'b0;
      repeat (4) step();

      // Contention from reset state: A first, then alternate; B held while stalled
      wb_if.a_valid = 1'b1; wb_if.a_reg = 4'd1; wb_if.a_data = 16'hA001;
      wb_if.b_valid = 1'b1; wb_if.b_reg = 4'd8; wb_if.b_data = 16'hB001;
      settle();
      check("rr1_a_ready", 32'(wb_if.a_ready), 32'd1);
      check("rr1_b_ready", 32'(wb_if.b_ready), 32'd0);
      step();
      check_write("rr1", 1'b1, 4'd1, 16'hA001);
      wb_if.a_reg = 4'd2; wb_if.a_data = 16'hA002;
      settle();
      check("rr2_b_ready", 32'(wb_if.b_ready), 32'd1);
      check("rr2_a_ready", 32'(wb_if.a_ready), 32'd0);
      step();
      check_write("rr2", 1'b1, 4'd8, 16'hB001);
      wb_if.b_reg = 4'd9; wb_if.b_data = 16'hB002;
      settle();
      check("rr3_a_ready", 32'(wb_if.a_ready), 32'd1);
      step();
      check_write("rr3", 1'b1, 4'd2, 16'hA002);
      wb_if.a_valid = 1'b0;
      settle();
      check("rr4_b_ready", 32'(wb_if.b_ready), 32'd1);
      step();
      check_write("rr4", 1'b1, 4'd9, 16'hB002);
      wb_if.b_valid = 1'b0;
      step();
      check_write("rr_idle", 1'b0, 4'd9, 16'hB002);

      // Single A write
      wb_if.a_valid = 1'b1; wb_if.a_reg = 4'd3; wb_if.a_data = 16'h1234;
      settle();
      check("sa_a_ready", 32'(wb_if.a_ready), 32'd1);
      check("sa_b_ready", 32'(wb_if.b_ready), 32'd0);
      step();
      wb_if.a_valid = 1'b0;
      check_write("sa", 1'b1, 4'd3, 16'h1234);
      step();
      check_write("sa_hold", 1'b0, 4'd3, 16'h1234);

      // Same destination from both sources: last grant was A, so B goes first
      wb_if.a_valid = 1'b1; wb_if.a_reg = 4'd4; wb_if.a_data = 16'h1111;
      wb_if.b_valid = 1'b1; wb_if.b_reg = 4'd4; wb_if.b_data = 16'h2222;
      settle();
      check("sd_b_ready", 32'(wb_if.b_ready), 32'd1);
      step();
      check_write("sd1", 1'b1, 4'd4, 16'h2222);
      wb_if.b_valid = 1'b0;
      settle();
      check("sd_a_ready", 32'(wb_if.a_ready), 32'd1);
      step();
      check_write("sd2", 1'b1, 4'd4, 16'h1111);
      wb_if.a_valid = 1'b0;

      // Scoreboard set by issue, cleared the cycle after the commit edge
      wb_if.read_reg1 = 4'd5; wb_if.read_reg2 = 4'd6;
      wb_if.issue_valid = 1'b1; wb_if.issue_reg = 4'd5;
      settle();
      check("sb_busy1_pre", 32'(wb_if.busy1), 32'd0);
      step();
      wb_if.issue_valid = 1'b0;
      check("sb_busy1_set", 32'(wb_if.busy1), 32'd1);
      check("sb_busy2_clr", 32'(wb_if.busy2), 32'd0);
      wb_if.b_valid = 1'b1; wb_if.b_reg = 4'd5; wb_if.b_data = 16'h5555;
      settle();
      check("sb_b_ready", 32'(wb_if.b_ready), 32'd1);
      step();
      wb_if.b_valid = 1'b0;
      check_write("sb_wr", 1'b1, 4'd5, 16'h5555);
      check("sb_busy1_inwr", 32'(wb_if.busy1), 32'd1);
      step();
      check("sb_busy1_drop", 32'(wb_if.busy1), 32'd0);

      // Set/clear collision on r7: set wins
      wb_if.read_reg2 = 4'd7;
      wb_if.issue_valid = 1'b1; wb_if.issue_reg = 4'd7;
      step();
      wb_if.issue_valid = 1'b0;
      check("col_busy2_set", 32'(wb_if.busy2), 32'd1);
      wb_if.a_valid = 1'b1; wb_if.a_reg = 4'd7; wb_if.a_data = 16'h7777;
      step();
      wb_if.a_valid = 1'b0;
      check_write("col_wr", 1'b1, 4'd7, 16'h7777);
      wb_if.issue_valid = 1'b1; wb_if.issue_reg = 4'd7;
      step();
      wb_if.issue_valid = 1'b0;
      check("col_busy2_kept", 32'(wb_if.busy2), 32'd1);
      step();
      check("col_busy2_idle", 32'(wb_if.busy2), 32'd1);
      wb_if.a_valid = 1'b1; wb_if.a_reg = 4'd7; wb_if.a_data = 16'h0777;
      step();
      wb_if.a_valid = 1'b0;
      step();
      check("col_busy2_clr", 32'(wb_if.busy2), 32'd0);

      // Reset mid-operation with a write in flight and A still requesting
      wb_if.issue_valid = 1'b1; wb_if.issue_reg = 4'd5;
      wb_if.a_valid = 1'b1; wb_if.a_reg = 4'd10; wb_if.a_data = 16'hABCD;
      step();
      wb_if.issue_valid = 1'b0;
      check("mr_busy1_pre", 32'(wb_if.busy1), 32'd1);
      check_write("mr_pre", 1'b1, 4'd10, 16'hABCD);
      #3 reset = 1'b1;
      #1;
      check_write("mr_rst", 1'b0, 4'd0, 16'h0000);
      check("mr_busy1", 32'(wb_if.busy1), 32'd0);
      check("mr_busy2", 32'(wb_if.busy2), 32'd0);
      check("mr_a_ready", 32'(wb_if.a_ready), 32'd0);
      #1 reset = 1'b0;
      wb_if.a_valid = 1'b0;
      step();
      check("mr_wen_after", 32'(wb_if.reg_write_en), 32'd0);
      wb_if.a_valid = 1'b1; wb_if.a_reg = 4'd1; wb_if.a_data = 16'h0101;
      wb_if.b_valid = 1'b1; wb_if.b_reg = 4'd2; wb_if.b_data = 16'h0202;
      settle();
      check("mr_last_b_a_rdy", 32'(wb_if.a_ready), 32'd1);
      check("mr_last_b_b_rdy", 32'(wb_if.b_ready), 32'd0);
      step();
      wb_if.a_valid = 1'b0; wb_if.b_valid = 1'b0;
      check_write("mr_post", 1'b1, 4'd1, 16'h0101);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
